// File: rtl/tristate_line_receiver.sv
// rtl/tristate_line_receiver.sv - receive end of the pulled-up half-duplex line
// Two-flop sync, mid-bit sampling, one word per frame with valid/error pulses.
module tristate_line_receiver #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int H     = BIT_CYCLES / 2;
  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t            state, state_n;
  logic              s1, s2;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n, data_n;
  logic              valid_n, err_n;
  logic              cnt_last;

  assign cnt_last = (cnt == CNT_W'(BIT_CYCLES - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b1;
      s2         <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      s1         <= line_in;
      s2         <= s1;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data_out;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!s2) state_n = START;
      end
      // A start bit that is no longer low at mid-bit is treated as a glitch.
      START: begin
        if (cnt == CNT_W'(H - 1)) begin
          cnt_n = '0;
          if (s2) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = s2;
          if (bit_idx == BIT_W'(DATA_W - 1)) state_n = STOP;
          else bit_idx_n = bit_idx + BIT_W'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (s2) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_HI;
          end
        end
      end
      // Bus held low after a bad stop: wait for release before hunting again.
      WAIT_HI: begin
        cnt_n = '0;
        if (s2) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tristate_line_receiver.sv
// tb/tb_tristate_line_receiver.sv - scoreboard bench for tristate_line_receiver
// Frames are driven bit by bit; expected pulses are queued and checked by a monitor.
module tb_tristate_line_receiver;

  localparam int DW  = 8;
  localparam int BC  = 16;
  localparam int H   = BC / 2;
  localparam int LAT = 1 + 2 + H + (DW + 1) * BC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  tristate_line_receiver #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] last_good = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic hold(input logic v, input int n);
    line_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse lands LAT edges after the drive point: E0 is the next edge, result after E154.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input bit report);
    exp_t e;
    if (report) begin
      e.err  = !stop_ok;
      e.data = stop_ok ? d : last_good;
      e.at   = cyc + LAT;
      q.push_back(e);
      if (stop_ok) last_good = d;
    end
    hold(1'b0, BC);
    for (int i = 0; i < DW; i++) hold(d[i], BC);
    hold(stop_ok, BC);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (data_valid || frame_err)) begin
      chk("pulse_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", q.size(), 32'd1);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
        chk("pulse_data", {24'd0, data_out}, {24'd0, e.data});
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bit            ok;
    int            w;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", {24'd0, data_out}, 32'd0);
    chk("reset_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      hold(1'b1, 50);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("frame_a5", {24'd0, data_out}, 32'hA5);

    hold(1'b0, 5);
    hold(1'b1, 2);
    chk("glitch_busy_start", {31'd0, busy}, 32'd1);
    hold(1'b1, 20);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_data", {24'd0, data_out}, 32'hA5);

    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b0, 100);
    chk("stuck_busy", {31'd0, busy}, 32'd1);
    chk("stuck_data", {24'd0, data_out}, 32'hA5);
    hold(1'b1, BC);
    chk("released_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("frame_5a", {24'd0, data_out}, 32'h5A);

    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("b2b_last", {24'd0, data_out}, 32'hFF);

    // Upper bits of 0xF5 are all 1 so the abandoned remainder cannot look like a start bit.
    fork
      send_frame(8'hF5, 1'b1, 1'b0);
      begin
        repeat (5 * BC + H) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_data_out", {24'd0, data_out}, 32'd0);
        chk("midreset_valid", {31'd0, data_valid}, 32'd0);
        chk("midreset_err", {31'd0, frame_err}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        last_good = '0;
      end
    join
    hold(1'b1, 20);
    chk("after_reset_data", {24'd0, data_out}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("frame_81", {24'd0, data_out}, 32'h81);

    for (int i = 0; i < 20; i++) begin
      d  = DW'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, 1'b1);
      if (!ok) begin
        hold(1'b0, $urandom_range(0, 40));
        hold(1'b1, $urandom_range(BC, 2 * BC));
      end else begin
        hold(1'b1, $urandom_range(0, 20));
      end
    end
    hold(1'b1, 20);
    chk("random_last_good", {24'd0, data_out}, {24'd0, last_good});

    w = 0;
    while (q.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
